// File: rtl/pie_frame_encoder.sv
// PIE frame transmitter for the reader downlink.
// Emits delimiter, data-0, RTcal, optional TRcal, then one PIE symbol per
// data bit pulled over a valid/ready strobe, followed by a CW gap.
// Symbol timings are latched at frame start from the cfg_* inputs.
module pie_frame_encoder #(
    parameter int CNT_W     = 12,
    parameter int DELIMITER = 312,
    parameter int GAP_MIN   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             start_rdy,
    input  logic             preamble,
    input  logic [CNT_W-1:0] cfg_pw,
    input  logic [CNT_W-1:0] cfg_zero,
    input  logic [CNT_W-1:0] cfg_one,
    input  logic [CNT_W-1:0] cfg_rtcal,
    input  logic [CNT_W-1:0] cfg_trcal,
    input  logic             s_valid,
    input  logic             s_data,
    input  logic             s_last,
    output logic             s_ready,
    output logic             pie,
    output logic             busy,
    output logic             done,
    output logic             underflow,
    output logic             cfg_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DELIM = 3'd1,
        S_SYNC0 = 3'd2,
        S_RTCAL = 3'd3,
        S_TRCAL = 3'd4,
        S_DATA  = 3'd5,
        S_GAP   = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] DELIM_LEN = CNT_W'(DELIMITER);
    localparam logic [CNT_W-1:0] GAP_LEN   = CNT_W'(GAP_MIN);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] pw_q;
    logic [CNT_W-1:0] zero_q;
    logic [CNT_W-1:0] one_q;
    logic [CNT_W-1:0] rtcal_q;
    logic [CNT_W-1:0] trcal_q;
    logic             pre_q;
    logic             bit_q;
    logic             last_q;
    logic             pie_q;
    logic             busy_q;
    logic             done_q;
    logic             underflow_q;
    logic             cfg_err_q;

    logic [CNT_W-1:0] len_s;
    logic             seg_end_s;
    logic             high_s;
    logic             pie_d;
    logic             fetch_s;
    logic             cfg_ok_s;

    // Length of the segment or symbol the counter is currently timing.
    always_comb begin
        len_s = GAP_LEN;
        case (state_q)
            S_DELIM: len_s = DELIM_LEN;
            S_SYNC0: len_s = zero_q;
            S_RTCAL: len_s = rtcal_q;
            S_TRCAL: len_s = trcal_q;
            S_DATA:  len_s = bit_q ? one_q : zero_q;
            S_GAP:   len_s = GAP_LEN;
            default: len_s = GAP_LEN;
        endcase
    end

    assign seg_end_s = (cnt_q == (len_s - CNT_ONE));
    // The low pulse occupies the final cfg_pw cycles of every symbol.
    assign high_s    = (cnt_q < (len_s - pw_q));

    // Strict ordering of the timings; TRcal only matters with a full preamble.
    assign cfg_ok_s = (cfg_pw != CNT_ZERO) && (cfg_pw < cfg_zero) &&
                      (cfg_zero < cfg_one) && (cfg_one < cfg_rtcal) &&
                      (!preamble || (cfg_rtcal < cfg_trcal));

    // Bit fetch happens on the last cycle of the segment preceding each data symbol.
    always_comb begin
        fetch_s = 1'b0;
        case (state_q)
            S_RTCAL: fetch_s = seg_end_s && !pre_q;
            S_TRCAL: fetch_s = seg_end_s;
            S_DATA:  fetch_s = seg_end_s && !last_q;
            default: fetch_s = 1'b0;
        endcase
    end

    // Carrier level implied by the current state and counter (pin is one cycle later).
    always_comb begin
        pie_d = 1'b1;
        case (state_q)
            S_IDLE:  pie_d = 1'b1;
            S_DELIM: pie_d = 1'b0;
            S_SYNC0: pie_d = high_s;
            S_RTCAL: pie_d = high_s;
            S_TRCAL: pie_d = high_s;
            S_DATA:  pie_d = high_s;
            S_GAP:   pie_d = 1'b1;
            default: pie_d = 1'b1;
        endcase
    end

    // Frame sequencer with latched configuration and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= CNT_ZERO;
            pw_q        <= CNT_ZERO;
            zero_q      <= CNT_ZERO;
            one_q       <= CNT_ZERO;
            rtcal_q     <= CNT_ZERO;
            trcal_q     <= CNT_ZERO;
            pre_q       <= 1'b0;
            bit_q       <= 1'b0;
            last_q      <= 1'b0;
            pie_q       <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            underflow_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            pie_q       <= pie_d;
            done_q      <= 1'b0;
            underflow_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            if (state_q == S_IDLE) begin
                cnt_q <= CNT_ZERO;
                if (start && cfg_ok_s) begin
                    pw_q    <= cfg_pw;
                    zero_q  <= cfg_zero;
                    one_q   <= cfg_one;
                    rtcal_q <= cfg_rtcal;
                    trcal_q <= cfg_trcal;
                    pre_q   <= preamble;
                    last_q  <= 1'b0;
                    busy_q  <= 1'b1;
                    state_q <= S_DELIM;
                end else if (start) begin
                    cfg_err_q <= 1'b1;
                end else begin
                    busy_q <= 1'b0;
                end
            end else if (!seg_end_s) begin
                cnt_q <= cnt_q + CNT_ONE;
            end else begin
                cnt_q <= CNT_ZERO;
                if (fetch_s && s_valid) begin
                    bit_q   <= s_data;
                    last_q  <= s_last;
                    state_q <= S_DATA;
                end else if (fetch_s) begin
                    underflow_q <= 1'b1;
                    state_q     <= S_GAP;
                end else begin
                    case (state_q)
                        S_DELIM: state_q <= S_SYNC0;
                        S_SYNC0: state_q <= S_RTCAL;
                        S_RTCAL: state_q <= S_TRCAL;
                        S_TRCAL: state_q <= S_DATA;
                        S_DATA: begin
                            done_q  <= 1'b1;
                            state_q <= S_GAP;
                        end
                        S_GAP: begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                        default: state_q <= S_IDLE;
                    endcase
                end
            end
        end
    end

    assign start_rdy = (state_q == S_IDLE);
    assign s_ready   = fetch_s;
    assign pie       = pie_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign underflow = underflow_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_pie_frame_encoder.sv
// Directed bench for pie_frame_encoder: a table of frame vectors checked
// against a run-length PIE model, plus reset, literal-waveform and
// random-payload sequences.
module tb_pie_frame_encoder;

    localparam int CNT_W = 12;
    localparam int DLM   = 3;
    localparam int GAPN  = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic             start_rdy;
    logic             preamble;
    logic [CNT_W-1:0] cfg_pw;
    logic [CNT_W-1:0] cfg_zero;
    logic [CNT_W-1:0] cfg_one;
    logic [CNT_W-1:0] cfg_rtcal;
    logic [CNT_W-1:0] cfg_trcal;
    logic             s_valid;
    logic             s_data;
    logic             s_last;
    logic             s_ready;
    logic             pie;
    logic             busy;
    logic             done;
    logic             underflow;
    logic             cfg_err;

    pie_frame_encoder #(.CNT_W(CNT_W), .DELIMITER(DLM), .GAP_MIN(GAPN)) dut (
        .clk(clk), .rst(rst), .start(start), .start_rdy(start_rdy),
        .preamble(preamble), .cfg_pw(cfg_pw), .cfg_zero(cfg_zero),
        .cfg_one(cfg_one), .cfg_rtcal(cfg_rtcal), .cfg_trcal(cfg_trcal),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .pie(pie), .busy(busy), .done(done), .underflow(underflow),
        .cfg_err(cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pre;
        int          pw;
        int          zero;
        int          one;
        int          rtcal;
        int          trcal;
        int          nbits;
        logic [63:0] bits;
        int          abort_at;
        logic        exp_err;
        logic        stall;
    } vec_t;

    vec_t vecs[10];
    int   checks = 0;
    int   errors = 0;
    logic last_wave[$];

    int run_val[12] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    int run_len[12] = '{3, 3, 2, 11, 2, 18, 2, 6, 2, 3, 2, 4};

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int i, input logic pre, input int pw, input int zero,
                           input int one, input int rtcal, input int trcal, input int nbits,
                           input logic [63:0] bits, input int abort_at, input logic exp_err,
                           input logic stall);
        vecs[i].pre = pre;   vecs[i].pw = pw;       vecs[i].zero = zero;
        vecs[i].one = one;   vecs[i].rtcal = rtcal; vecs[i].trcal = trcal;
        vecs[i].nbits = nbits; vecs[i].bits = bits; vecs[i].abort_at = abort_at;
        vecs[i].exp_err = exp_err; vecs[i].stall = stall;
    endtask

    task automatic push_sym(inout logic q[$], input int len, input int pw);
        for (int k = 0; k < len - pw; k++) q.push_back(1'b1);
        for (int k = 0; k < pw; k++) q.push_back(1'b0);
    endtask

    task automatic drive_cfg(input vec_t v);
        preamble  = v.pre;
        cfg_pw    = v.pw[CNT_W-1:0];
        cfg_zero  = v.zero[CNT_W-1:0];
        cfg_one   = v.one[CNT_W-1:0];
        cfg_rtcal = v.rtcal[CNT_W-1:0];
        cfg_trcal = v.trcal[CNT_W-1:0];
    endtask

    task automatic run_vec(input int id, input vec_t v);
        logic exp_q[$];
        int   n_done, n_under, n_err, n_rdy, fetch_idx, ev_cyc, idle_cyc, cyc;
        int   busy_bad, bad, mism, ev_exp, n_sent;
        bit   fin;
        exp_q.delete();
        last_wave.delete();
        n_done = 0; n_under = 0; n_err = 0; n_rdy = 0; fetch_idx = 0;
        ev_cyc = -1; idle_cyc = -1; busy_bad = 0; fin = 1'b0;
        chk($sformatf("v%0d_start_rdy", id), int'(start_rdy), 1);
        drive_cfg(v);
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        if (v.exp_err) begin
            bad = 0;
            for (int k = 0; k < 6; k++) begin
                if (cfg_err === 1'b1) n_err++;
                if (pie !== 1'b1 || busy !== 1'b0 || start_rdy !== 1'b1) bad++;
                step();
            end
            chk($sformatf("v%0d_cfg_err_pulses", id), n_err, 1);
            chk($sformatf("v%0d_idle_hold", id), bad, 0);
            return;
        end
        // expected waveform from the symbol definition
        for (int k = 0; k < DLM; k++) exp_q.push_back(1'b0);
        push_sym(exp_q, v.zero, v.pw);
        push_sym(exp_q, v.rtcal, v.pw);
        if (v.pre) push_sym(exp_q, v.trcal, v.pw);
        n_sent = (v.abort_at >= 0) ? v.abort_at : v.nbits;
        for (int k = 0; k < n_sent; k++) push_sym(exp_q, v.bits[k] ? v.one : v.zero, v.pw);
        ev_exp = exp_q.size() + 1;
        for (int k = 0; k < GAPN; k++) exp_q.push_back(1'b1);

        while (!fin && cyc < 2000) begin
            if (cyc >= 2) last_wave.push_back(pie);
            if (done === 1'b1) begin n_done++; if (ev_cyc < 0) ev_cyc = cyc; end
            if (underflow === 1'b1) begin n_under++; if (ev_cyc < 0) ev_cyc = cyc; end
            if (cfg_err === 1'b1) n_err++;
            if (busy !== !start_rdy) busy_bad++;
            if (start_rdy === 1'b1 && cyc >= 2) begin
                fin = 1'b1;
                idle_cyc = cyc;
                start = 1'b0;
                s_valid = 1'b0;
            end else begin
                if (s_ready === 1'b1) begin
                    n_rdy++;
                    s_valid = (fetch_idx != v.abort_at);
                    s_data  = v.bits[fetch_idx];
                    s_last  = (fetch_idx == v.nbits - 1);
                    fetch_idx++;
                end else if (v.stall) begin
                    s_valid  = 1'($urandom_range(0, 1));
                    s_data   = 1'($urandom_range(0, 1));
                    s_last   = 1'($urandom_range(0, 1));
                    start    = 1'($urandom_range(0, 1));
                    preamble = 1'($urandom_range(0, 1));
                    cfg_one  = CNT_W'($urandom_range(0, 4095));
                    cfg_pw   = CNT_W'($urandom_range(0, 4095));
                end else begin
                    s_valid = 1'b0;
                end
                step();
                cyc++;
            end
        end
        start = 1'b0;
        s_valid = 1'b0;
        chk($sformatf("v%0d_terminated", id), int'(fin), 1);
        mism = 0;
        for (int k = 0; k < exp_q.size() && k < last_wave.size(); k++)
            if (last_wave[k] !== exp_q[k]) mism++;
        chk($sformatf("v%0d_pie_len", id), last_wave.size(), exp_q.size());
        chk($sformatf("v%0d_pie_mismatches", id), mism, 0);
        chk($sformatf("v%0d_done_count", id), n_done, (v.abort_at >= 0) ? 0 : 1);
        chk($sformatf("v%0d_underflow_count", id), n_under, (v.abort_at >= 0) ? 1 : 0);
        chk($sformatf("v%0d_s_ready_pulses", id), n_rdy,
            (v.abort_at >= 0) ? v.abort_at + 1 : v.nbits);
        chk($sformatf("v%0d_event_cycle", id), ev_cyc, ev_exp);
        chk($sformatf("v%0d_idle_cycle", id), idle_cyc, ev_exp + GAPN);
        chk($sformatf("v%0d_busy_bad", id), busy_bad, 0);
        chk($sformatf("v%0d_no_cfg_err", id), n_err, 0);
    endtask

    task automatic lit_check(input string name);
        logic lit[$];
        int   mism;
        lit.delete();
        for (int r = 0; r < 12; r++)
            for (int k = 0; k < run_len[r]; k++) lit.push_back(1'(run_val[r]));
        mism = 0;
        for (int k = 0; k < lit.size() && k < last_wave.size(); k++)
            if (last_wave[k] !== lit[k]) mism++;
        chk({name, "_len"}, last_wave.size(), lit.size());
        chk({name, "_mismatches"}, mism, 0);
    endtask

    task automatic decode_check(input vec_t v);
        logic [63:0] dec;
        int p, lim, nd, badlen, l;
        dec = 64'd0;
        p = DLM + v.zero + v.rtcal + (v.pre ? v.trcal : 0);
        lim = last_wave.size() - GAPN;
        nd = 0;
        badlen = 0;
        while (p < lim && nd < 64) begin
            l = 0;
            while (p < lim && last_wave[p] === 1'b1) begin l++; p++; end
            while (p < lim && last_wave[p] === 1'b0) begin l++; p++; end
            if (l == v.one) dec[nd] = 1'b1;
            else if (l != v.zero) badlen++;
            nd++;
        end
        chk("rand_symbol_count", nd, v.nbits);
        chk("rand_bad_symbol_len", badlen, 0);
        checks++;
        if (dec !== v.bits) begin
            errors++;
            $display("FAIL rand_decoded_bits: got %h expected %h", dec, v.bits);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; preamble = 1'b0;
        cfg_pw = '0; cfg_zero = '0; cfg_one = '0; cfg_rtcal = '0; cfg_trcal = '0;
        s_valid = 1'b0; s_data = 1'b0; s_last = 1'b0;
        repeat (3) step();
        chk("reset_outputs", int'({pie, start_rdy, s_ready, busy, done, underflow, cfg_err}),
            int'(7'b1100000));
        rst = 1'b0;
        step();
        chk("post_reset_outputs", int'({pie, start_rdy, s_ready, busy, done, underflow, cfg_err}),
            int'(7'b1100000));

        set_vec(0, 1'b1, 2, 5, 8, 13, 20, 2, 64'h1, -1, 1'b0, 1'b0);
        set_vec(1, 1'b0, 2, 5, 8, 13, 20, 1, 64'h0, -1, 1'b0, 1'b0);
        set_vec(2, 1'b0, 2, 5, 8, 13, 20, 2, 64'h3,  1, 1'b0, 1'b0);
        set_vec(3, 1'b1, 2, 5, 5, 13, 20, 2, 64'h1, -1, 1'b1, 1'b0);
        set_vec(4, 1'b0, 0, 5, 8, 13, 20, 2, 64'h1, -1, 1'b1, 1'b0);
        set_vec(5, 1'b0, 1, 3, 4,  6,  0, 3, 64'h5, -1, 1'b0, 1'b0);
        set_vec(6, 1'b1, 2, 5, 8, 13, 13, 2, 64'h1, -1, 1'b1, 1'b0);
        set_vec(7, 1'b1, 2, 5, 8, 13, 20, 3, 64'h7,  0, 1'b0, 1'b0);
        set_vec(8, 1'b1, 1, 2, 3,  4,  5, 4, 64'h6, -1, 1'b0, 1'b0);
        set_vec(9, 1'b1, 2, 5, 8, 13, 20, 64, {$urandom, $urandom}, -1, 1'b0, 1'b1);

        for (int i = 0; i < 10; i++) begin
            run_vec(i, vecs[i]);
            if (i == 0) lit_check("frame1_literal");
            if (i == 9) decode_check(vecs[9]);
            repeat (2) step();
        end

        // reset during the RTCAL low pulse
        drive_cfg(vecs[0]);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (21) step();
        chk("pie_low_before_rst", int'(pie), 0);
        rst = 1'b1;
        #1;
        chk("pie_async_reset", int'(pie), 1);
        chk("busy_async_reset", int'(busy), 0);
        chk("start_rdy_async_reset", int'(start_rdy), 1);
        step();
        chk("no_pulse_in_reset", int'({done, underflow, cfg_err}), 0);
        rst = 1'b0;
        step();
        run_vec(10, vecs[0]);
        lit_check("frame_after_reset_literal");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
